// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Host-side bundle of pwm_duty_ramp_ctrl: the target handshake, abort, the generator
// button outputs and the status outputs.
interface pwm_duty_ramp_ctrl_if #(
  parameter int DUTY_W = 4
);
  logic              tgt_valid;
  logic              tgt_ready;
  logic [DUTY_W-1:0] tgt_duty;
  logic              abort;
  logic              increase_duty;
  logic              decrease_duty;
  logic [DUTY_W-1:0] cur_duty;
  logic              busy;
  logic              done;

  modport master (
    output tgt_valid, tgt_duty, abort,
    input  tgt_ready, increase_duty, decrease_duty, cur_duty, busy, done
  );

  modport slave (
    input  tgt_valid, tgt_duty, abort,
    output tgt_ready, increase_duty, decrease_duty, cur_duty, busy, done
  );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Steps the 10-step PWM generator's duty toward a host target using timed button pulses.
// The optional PWM_RAMP_RETARGET_EN build accepts a new target while the FSM is in GAP.
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W       = 4,
  parameter int MAX_DUTY     = 10,
  parameter int INIT_DUTY    = 5,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int CNT_W        = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  pwm_duty_ramp_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [DUTY_W-1:0] MAX_D      = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] INIT_D     = DUTY_W'(INIT_DUTY);
  localparam logic [CNT_W-1:0]  PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [DUTY_W-1:0] cur_q, cur_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              up_q, up_d;
  logic              abort_q, abort_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic              done_q, done_d;
  logic              ready;
  logic              accept;
  logic [DUTY_W-1:0] tgt_clamped;

`ifdef PWM_RAMP_RETARGET_EN
  assign ready = (state_q == IDLE) || (state_q == GAP);
`else
  assign ready = (state_q == IDLE);
`endif

  assign accept      = bus.tgt_valid & ready;
  assign tgt_clamped = (bus.tgt_duty > MAX_D) ? MAX_D : bus.tgt_duty;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cur_d    = cur_q;
    target_d = target_q;
    up_d     = up_q;
    abort_d  = abort_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (accept) begin
          target_d = tgt_clamped;
          up_d     = (tgt_clamped > cur_q);
          if (tgt_clamped == cur_q) begin
            done_d = 1'b1;
          end else begin
            state_d = PRESS;
            timer_d = '0;
          end
        end
      end

      PRESS: begin
        abort_d = abort_q | bus.abort;
        if (timer_q == PRESS_LAST) begin
          // The shadow moves once per completed press, saturating at the legal range.
          if (up_q && (cur_q < MAX_D)) begin
            cur_d = cur_q + 1'b1;
          end else if (!up_q && (cur_q != '0)) begin
            cur_d = cur_q - 1'b1;
          end
          state_d = GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      GAP: begin
        abort_d = abort_q | bus.abort;
`ifdef PWM_RAMP_RETARGET_EN
        if (accept) begin
          target_d = tgt_clamped;
          up_d     = (tgt_clamped > cur_q);
          abort_d  = 1'b0;
        end
`endif
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          // Reaching the target outranks a pending abort.
          if (target_d == cur_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            abort_d = 1'b0;
          end else if (abort_d) begin
            state_d = IDLE;
            abort_d = 1'b0;
          end else begin
            state_d = PRESS;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    inc_d = (state_d == PRESS) &  up_d;
    dec_d = (state_d == PRESS) & ~up_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cur_q    <= INIT_D;
      target_q <= INIT_D;
      up_q     <= 1'b0;
      abort_q  <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      up_q     <= up_d;
      abort_q  <= abort_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      done_q   <= done_d;
    end
  end

  assign bus.tgt_ready     = ready;
  assign bus.increase_duty = inc_q;
  assign bus.decrease_duty = dec_q;
  assign bus.cur_duty      = cur_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl; expectations are the hand-derived cycle numbers
// of the ramp scenarios, with cycle k meaning the period after accept edge 0.
module tb_pwm_duty_ramp_ctrl;
  logic clk;
  logic rst_n;

  pwm_duty_ramp_ctrl_if #(.DUTY_W(4)) ramp_bus ();

  pwm_duty_ramp_ctrl #(
    .DUTY_W(4), .MAX_DUTY(10), .INIT_DUTY(5),
    .PRESS_CYCLES(4), .GAP_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ramp_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       inc_tr   [0:63];
  logic       dec_tr   [0:63];
  logic       done_tr  [0:63];
  logic       busy_tr  [0:63];
  logic       ready_tr [0:63];
  logic [3:0] cur_tr   [0:63];

  logic [63:0] inc_vec;
  int inc_rise, dec_rise, done_cyc, done_cnt, busy_cnt, both_cnt;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    ramp_bus.tgt_valid = 1'b0;
    ramp_bus.tgt_duty  = 4'd0;
    ramp_bus.abort     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Accepts tgt at edge 0, then records cycles 1..ncyc while driving abort, retarget and reset.
  task automatic applyStimulus(input logic [3:0] tgt, input int ncyc, input int abort_cyc,
                               input int retgt_cyc, input logic [3:0] retgt_val, input int rst_cyc);
    ramp_bus.tgt_duty  = tgt;
    ramp_bus.tgt_valid = 1'b1;
    tick();
    ramp_bus.tgt_valid = 1'b0;
    inc_tr[0] = 1'b0;
    dec_tr[0] = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      inc_tr[k]   = ramp_bus.increase_duty;
      dec_tr[k]   = ramp_bus.decrease_duty;
      done_tr[k]  = ramp_bus.done;
      busy_tr[k]  = ramp_bus.busy;
      ready_tr[k] = ramp_bus.tgt_ready;
      cur_tr[k]   = ramp_bus.cur_duty;
      ramp_bus.abort     = (k == abort_cyc);
      ramp_bus.tgt_valid = (k == retgt_cyc);
      ramp_bus.tgt_duty  = (k == retgt_cyc) ? retgt_val : tgt;
      rst_n              = !(k == rst_cyc);
      tick();
    end
    ramp_bus.abort     = 1'b0;
    ramp_bus.tgt_valid = 1'b0;
    rst_n              = 1'b1;
    inc_vec  = '0;
    inc_rise = 0;
    dec_rise = 0;
    done_cyc = 0;
    done_cnt = 0;
    busy_cnt = 0;
    both_cnt = 0;
    for (int k = 1; k <= ncyc; k++) begin
      inc_vec[k] = inc_tr[k];
      if (inc_tr[k] && !inc_tr[k-1]) inc_rise++;
      if (dec_tr[k] && !dec_tr[k-1]) dec_rise++;
      if (done_tr[k]) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (busy_tr[k]) busy_cnt++;
      if (inc_tr[k] && dec_tr[k]) both_cnt++;
    end
  endtask

  initial begin
    resetDut();
    checkOutput("rst_ready", ramp_bus.tgt_ready, 1);
    checkOutput("rst_busy", ramp_bus.busy, 0);
    checkOutput("rst_done", ramp_bus.done, 0);
    checkOutput("rst_inc", ramp_bus.increase_duty, 0);
    checkOutput("rst_dec", ramp_bus.decrease_duty, 0);
    checkOutput("rst_cur", ramp_bus.cur_duty, 5);

    // Target 7: two up steps.
    applyStimulus(4'd7, 20, 0, 0, 4'd0, 0);
    checkOutput("up7_inc_pattern", inc_vec[20:0], 21'h01E1E);
    checkOutput("up7_cur_c5", cur_tr[5], 6);
    checkOutput("up7_cur_c13", cur_tr[13], 7);
    checkOutput("up7_done_cyc", done_cyc, 17);
    checkOutput("up7_done_cnt", done_cnt, 1);
    checkOutput("up7_dec_rise", dec_rise, 0);
    checkOutput("up7_busy_c16", busy_tr[16], 1);
    checkOutput("up7_busy_c17", busy_tr[17], 0);
    checkOutput("up7_ready_c17", ready_tr[17], 1);
`ifndef PWM_RAMP_RETARGET_EN
    checkOutput("up7_ready_gap", ready_tr[6], 0);
`endif

    resetDut();
    applyStimulus(4'd0, 45, 0, 0, 4'd0, 0);
    checkOutput("dn0_dec_rise", dec_rise, 5);
    checkOutput("dn0_inc_rise", inc_rise, 0);
    checkOutput("dn0_done_cyc", done_cyc, 41);
    checkOutput("dn0_cur", cur_tr[45], 0);
    checkOutput("dn0_both", both_cnt, 0);

    resetDut();
    applyStimulus(4'd12, 45, 0, 0, 4'd0, 0);
    checkOutput("clamp_inc_rise", inc_rise, 5);
    checkOutput("clamp_cur", cur_tr[45], 10);
    checkOutput("clamp_done_cyc", done_cyc, 41);
    checkOutput("clamp_both", both_cnt, 0);

    resetDut();
    applyStimulus(4'd5, 10, 0, 0, 4'd0, 0);
    checkOutput("eq_done_cyc", done_cyc, 1);
    checkOutput("eq_done_cnt", done_cnt, 1);
    checkOutput("eq_busy_cnt", busy_cnt, 0);
    checkOutput("eq_pulses", inc_rise + dec_rise, 0);

    // Abort raised in the second press lets that step finish, then stops.
    resetDut();
    applyStimulus(4'd9, 24, 10, 0, 4'd0, 0);
    checkOutput("abort_inc_rise", inc_rise, 2);
    checkOutput("abort_cur", cur_tr[24], 7);
    checkOutput("abort_done_cnt", done_cnt, 0);
    checkOutput("abort_ready_c16", ready_tr[16], 0);
    checkOutput("abort_ready_c17", ready_tr[17], 1);
    checkOutput("abort_busy_c17", busy_tr[17], 0);

    resetDut();
    applyStimulus(4'd9, 10, 0, 0, 4'd0, 6);
    checkOutput("rstmid_cur_c6", cur_tr[6], 6);
    checkOutput("rstmid_busy_c6", busy_tr[6], 1);
    checkOutput("rstmid_busy_c7", busy_tr[7], 0);
    checkOutput("rstmid_ready_c7", ready_tr[7], 1);
    checkOutput("rstmid_inc_c7", inc_tr[7], 0);
    checkOutput("rstmid_dec_c7", dec_tr[7], 0);
    checkOutput("rstmid_done_c7", done_tr[7], 0);
    checkOutput("rstmid_cur_c7", cur_tr[7], 5);
    checkOutput("rstmid_no_restart", busy_cnt, 6);

`ifdef PWM_RAMP_RETARGET_EN
    resetDut();
    applyStimulus(4'd9, 20, 0, 6, 4'd6, 0);
    checkOutput("retgt_inc_rise", inc_rise, 1);
    checkOutput("retgt_cur", cur_tr[20], 6);
    checkOutput("retgt_done_cyc", done_cyc, 9);
    checkOutput("retgt_ready_gap", ready_tr[6], 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
